// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock for a programmable
// time, then releases the downstream synchronous reset; retries on timeout, faults after MAX_RETRIES.
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 32,
    parameter int unsigned MAX_RETRIES        = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retry_count
);
    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_HOLD,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [3:0]             r_retry;
    logic                   r_lock_lost;
    logic                   w_locked_s;
    logic                   w_retry_bump;
    logic [3:0]             w_retry_inc;

    assign w_locked_s  = r_sync[SYNC_STAGES-1];
    assign w_retry_inc = r_retry + 4'd1;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_retry_bump = 1'b0;
        case (r_state)
            S_PLL_RESET: begin
                if (r_cnt == CW'(PLL_RST_CYCLES - 1)) w_next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // lock takes priority over a coincident timeout
                if (w_locked_s) begin
                    w_next_state = S_STABLE;
                end else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    w_retry_bump = 1'b1;
                    w_next_state = (w_retry_inc == 4'(MAX_RETRIES)) ? S_FAULT : S_PLL_RESET;
                end
            end
            S_STABLE: begin
                if (!w_locked_s)                                   w_next_state = S_WAIT_LOCK;
                else if (r_cnt == CW'(LOCK_STABLE_CYCLES - 1))     w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (!w_locked_s)                                   w_next_state = S_WAIT_LOCK;
                else if (r_cnt == CW'(RST_HOLD_CYCLES - 1))        w_next_state = S_RUN;
            end
            S_RUN: begin
                if (!w_locked_s) w_next_state = S_PLL_RESET;
            end
            S_FAULT: w_next_state = S_FAULT;
            default: w_next_state = S_PLL_RESET;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state     <= S_PLL_RESET;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state != S_RUN && r_state != S_FAULT) begin
                r_cnt <= r_cnt + CW'(1);
            end
            // one-cycle flag coincides with the first cycle of the new PLL reset pulse
            r_lock_lost <= (r_state == S_RUN) && (w_next_state == S_PLL_RESET);
            if (w_retry_bump && r_retry != 4'(MAX_RETRIES)) begin
                r_retry <= w_retry_inc;
            end else if (w_next_state == S_RUN && r_state != S_RUN) begin
                r_retry <= '0;
            end
        end
    end

    assign pll_rst     = (r_state == S_PLL_RESET) || (r_state == S_FAULT);
    assign sys_rst     = (r_state != S_RUN);
    assign ready       = (r_state == S_RUN);
    assign fault       = (r_state == S_FAULT);
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed test-plan scenarios plus random
// lock activity, all compared each cycle against a dwell-time based reference model.
module tb_pll_lock_supervisor;
    localparam int unsigned SS  = 2;
    localparam int unsigned PRC = 4;
    localparam int unsigned TO  = 20;
    localparam int unsigned LSC = 8;
    localparam int unsigned RHC = 4;
    localparam int unsigned MR  = 3;

    localparam int P_PRST  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_HOLD  = 3;
    localparam int P_RUN   = 4;
    localparam int P_FAULT = 5;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fault, lock_lost;
    logic [3:0] retry_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase, edge of entry, retry count, lock_lost flag, locked history
    int ph      = P_PRST;
    int t0      = 0;
    int t       = 0;
    int t_rel   = 0;
    int m_retry = 0;
    bit m_lost  = 1'b0;
    bit hist[$];

    always #10 refclk = ~refclk;

    pll_lock_supervisor #(
        .SYNC_STAGES       (SS),
        .PLL_RST_CYCLES    (PRC),
        .LOCK_TIMEOUT      (TO),
        .LOCK_STABLE_CYCLES(LSC),
        .RST_HOLD_CYCLES   (RHC),
        .MAX_RETRIES       (MR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, act, exp, t);
        end
    endtask

    task automatic enter(input int p);
        ph = p;
        t0 = t;
    endtask

    // one clock edge: advance the model with the inputs present at the edge, then compare
    task automatic step();
        bit ls;
        int d;
        @(posedge refclk);
        t++;
        if (rst) begin
            enter(P_PRST);
            m_retry = 0;
            m_lost  = 1'b0;
            hist    = {};
            for (int i = 0; i < int'(SS); i++) hist.push_back(1'b0);
        end else begin
            ls     = hist[SS-1];
            d      = t - t0;
            m_lost = 1'b0;
            case (ph)
                P_PRST: if (d >= int'(PRC)) enter(P_WAIT);
                P_WAIT: begin
                    if (ls) enter(P_STAB);
                    else if (d >= int'(TO)) begin
                        m_retry++;
                        if (m_retry == int'(MR)) enter(P_FAULT);
                        else enter(P_PRST);
                    end
                end
                P_STAB: begin
                    if (!ls) enter(P_WAIT);
                    else if (d >= int'(LSC)) enter(P_HOLD);
                end
                P_HOLD: begin
                    if (!ls) enter(P_WAIT);
                    else if (d >= int'(RHC)) begin
                        enter(P_RUN);
                        m_retry = 0;
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        enter(P_PRST);
                        m_lost = 1'b1;
                    end
                end
                default: ;
            endcase
            hist.push_front(bit'(locked));
            void'(hist.pop_back());
        end
        #1;
        chk("pll_rst",     32'(pll_rst),     32'(ph == P_PRST || ph == P_FAULT));
        chk("sys_rst",     32'(sys_rst),     32'(ph != P_RUN));
        chk("ready",       32'(ready),       32'(ph == P_RUN));
        chk("fault",       32'(fault),       32'(ph == P_FAULT));
        chk("lock_lost",   32'(lock_lost),   32'(m_lost));
        chk("retry_count", 32'(retry_count), 32'(m_retry));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_seq();
        rst = 1'b1;
        run(2);
        rst   = 1'b0;
        t_rel = t;
    endtask

    task automatic wait_ready(input string tag, input int budget, output int tr);
        tr = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ready === 1'b1) begin
                tr = t;
                break;
            end
        end
        chk(tag, 32'(ready), 32'd1);
    endtask

    task automatic wait_phase(input int p, input int budget);
        for (int i = 0; i < budget && ph != p; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst),     32'd1);
        chk({tag, "_sys_rst"}, 32'(sys_rst),     32'd1);
        chk({tag, "_ready"},   32'(ready),       32'd0);
        chk({tag, "_fault"},   32'(fault),       32'd0);
        chk({tag, "_retry"},   32'(retry_count), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall, t_lk, t_r, pulses, frise, cnt, prev_retry;
        bit prev, seen;
        for (int i = 0; i < int'(SS); i++) hist.push_back(1'b0);

        // clean acquisition
        reset_seq();
        check_reset_outputs("reset");
        fall = 0;
        for (int i = 0; i < 20 && fall == 0; i++) begin
            step();
            if (pll_rst === 1'b0) fall = t - t_rel;
        end
        chk("clean_prst_fall_edge", 32'(fall), 32'(PRC));
        run(2);
        locked = 1'b1;
        t_lk   = t;
        wait_ready("clean_ready_seen", 60, t_r);
        chk("clean_ready_latency", 32'(t_r - t_lk), 32'(SS + LSC + RHC + 1));
        chk("clean_retry", 32'(retry_count), 32'd0);
        chk("clean_fault", 32'(fault), 32'd0);

        // no lock: three pulses then fault
        locked = 1'b0;
        reset_seq();
        prev   = 1'b1;
        pulses = 1;
        frise  = 0;
        for (int i = 0; i < 90; i++) begin
            step();
            if (pll_rst === 1'b1 && !prev && fault !== 1'b1) pulses++;
            prev = pll_rst;
            if (fault === 1'b1 && frise == 0) frise = t - t_rel;
        end
        chk("nolock_pulses", 32'(pulses), 32'(MR));
        chk("nolock_fault_edge", 32'(frise), 32'(MR * (PRC + TO)));
        chk("nolock_retry", 32'(retry_count), 32'(MR));
        chk("nolock_pll_rst", 32'(pll_rst), 32'd1);
        chk("nolock_sys_rst", 32'(sys_rst), 32'd1);

        // reset out of FAULT restarts a normal sequence
        rst = 1'b1;
        step();
        check_reset_outputs("fault_rst");
        rst    = 1'b0;
        locked = 1'b1;
        wait_ready("fault_rst_ready_seen", 80, t_r);

        // glitch in STABLE
        reset_seq();
        wait_phase(P_STAB, 40);
        run(4);
        locked = 1'b0;
        step();
        locked = 1'b1;
        t_lk   = t;
        seen   = 1'b0;
        t_r    = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (pll_rst === 1'b1) seen = 1'b1;
            if (ready === 1'b1) begin
                t_r = t;
                break;
            end
        end
        chk("glitch_ready_seen", 32'(ready), 32'd1);
        chk("glitch_ready_latency", 32'(t_r - t_lk), 32'(SS + LSC + RHC + 1));
        chk("glitch_no_prst", 32'(seen), 32'd0);
        chk("glitch_retry", 32'(retry_count), 32'd0);

        // lock loss in RUN
        run(3);
        locked = 1'b0;
        t_lk   = t;
        for (int i = 0; i < 10 && lock_lost !== 1'b1; i++) step();
        chk("loss_latency", 32'(t - t_lk), 32'(SS + 1));
        chk("loss_pulse", 32'(lock_lost), 32'd1);
        chk("loss_sys_rst", 32'(sys_rst), 32'd1);
        chk("loss_ready", 32'(ready), 32'd0);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 0) chk("loss_pulse_width", 32'(lock_lost), 32'd0);
            if (pll_rst !== 1'b1) break;
            cnt++;
        end
        chk("loss_prst_width", 32'(cnt), 32'(PRC));
        locked = 1'b1;
        wait_ready("loss_reacquire", 60, t_r);
        chk("loss_retry_cleared", 32'(retry_count), 32'd0);

        // late lock after one timeout, with a toggle while in PLL_RESET
        locked = 1'b0;
        reset_seq();
        for (int i = 0; i < 60 && m_retry != 1; i++) step();
        locked = 1'b1;
        step();
        locked = 1'b0;
        run(7);
        locked     = 1'b1;
        prev_retry = -1;
        t_r        = -1;
        for (int i = 0; i < 60; i++) begin
            prev_retry = int'(retry_count);
            step();
            if (ready === 1'b1) begin
                t_r = t;
                break;
            end
        end
        chk("late_ready_seen", 32'(ready), 32'd1);
        chk("late_retry_before_run", 32'(prev_retry), 32'd1);
        chk("late_retry_in_run", 32'(retry_count), 32'd0);

        // mid-operation reset in RUN
        run(3);
        rst = 1'b1;
        step();
        check_reset_outputs("run_rst");
        rst = 1'b0;
        wait_ready("run_rst_restart", 60, t_r);

        // random lock activity with occasional resets
        for (int i = 0; i < 4000;) begin
            int len;
            locked = ($urandom_range(0, 9) < 7);
            len    = $urandom_range(1, 60);
            for (int j = 0; j < len; j++) begin
                rst = ($urandom_range(0, 499) == 0);
                step();
                i++;
            end
        end
        rst = 1'b0;
        run(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
